pipe_stage_reg: RTL and testbench

- Parametrised, handshaked pipeline register for the RISC-V main processor pipe.
- Generalises the fixed EX/MEM latch into a reusable stage for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.
- Carries an instruction word, a control bundle and a data bundle, with valid/ready backpressure, flush-to-NOP and freeze.
- Counts bubble cycles for performance analysis.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_skid_buf.sv | 49 ++++
 rtl/pipe_stage_reg.sv | 130 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and boundary widths for the handshaked pipeline stage registers.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR_HEX = 32'h0000_0013;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic [2:0] memType;
    logic       ecall;
    logic       branch;
  } ctrl_t;

  localparam int INSTR_W_DEF  = 32;
  localparam int CTRL_W_DEF   = $bits(ctrl_t);
  localparam int CNT_W_DEF    = 16;

  // Data bundle widths: PC plus the operands/results live at each boundary.
  localparam int IFID_DATA_W  = 32;
  localparam int IDEX_DATA_W  = 128;
  localparam int EXMEM_DATA_W = 96;
  localparam int MEMWB_DATA_W = 96;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid storage with its valid flag; only used when PIPE_SKID_EN is defined.
module pipe_skid_buf #(
  parameter int INSTR_W = 32,
  parameter int CTRL_W  = 8,
  parameter int DATA_W  = 96
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic               i_unload,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [CTRL_W-1:0]  i_ctrl,
  input  logic [DATA_W-1:0]  i_data,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [CTRL_W-1:0]  o_ctrl,
  output logic [DATA_W-1:0]  o_data
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [CTRL_W-1:0]  r_ctrl;
  logic [DATA_W-1:0]  r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush-to-NOP, freeze and a bubble counter.
// Defining PIPE_SKID_EN adds a one-entry skid buffer and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter int                 CTRL_W    = CTRL_W_DEF,
  parameter int                 DATA_W    = EXMEM_DATA_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_HEX),
  parameter int                 CNT_W     = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               hold,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [CTRL_W-1:0]  r_ctrl;
  logic [DATA_W-1:0]  r_data;
  logic [CNT_W-1:0]   r_bubbleCnt;

  logic               w_inXfer;
  logic               w_outXfer;
  logic               w_mainLoad;
  logic               w_mainDrain;
  logic [INSTR_W-1:0] w_nxtInstr;
  logic [CTRL_W-1:0]  w_nxtCtrl;
  logic [DATA_W-1:0]  w_nxtData;

  assign w_inXfer  = in_valid & in_ready;
  assign w_outXfer = r_valid & out_ready;

`ifdef PIPE_SKID_EN
  logic               w_skidValid;
  logic               w_skidLoad;
  logic               w_skidUnload;
  logic [INSTR_W-1:0] w_skidInstr;
  logic [CTRL_W-1:0]  w_skidCtrl;
  logic [DATA_W-1:0]  w_skidData;

  // in_ready depends only on the skid flag, so out_ready never reaches it combinationally.
  assign in_ready     = !rst & !hold & !w_skidValid;
  assign w_skidLoad   = !flush & !hold & w_inXfer & r_valid & !out_ready;
  assign w_skidUnload = !flush & !hold & w_skidValid & out_ready;
  assign w_mainLoad   = w_skidUnload | (w_inXfer & (!r_valid | out_ready));
  assign w_mainDrain  = w_outXfer & !w_mainLoad;
  assign w_nxtInstr   = w_skidValid ? w_skidInstr : in_instr;
  assign w_nxtCtrl    = w_skidValid ? w_skidCtrl  : in_ctrl;
  assign w_nxtData    = w_skidValid ? w_skidData  : in_data;

  pipe_skid_buf #(
    .INSTR_W (INSTR_W),
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (flush),
    .i_load   (w_skidLoad),
    .i_unload (w_skidUnload),
    .i_instr  (in_instr),
    .i_ctrl   (in_ctrl),
    .i_data   (in_data),
    .o_valid  (w_skidValid),
    .o_instr  (w_skidInstr),
    .o_ctrl   (w_skidCtrl),
    .o_data   (w_skidData)
  );
`else
  assign in_ready    = !rst & !hold & (!r_valid | out_ready);
  assign w_mainLoad  = w_inXfer;
  assign w_mainDrain = w_outXfer & !w_inXfer;
  assign w_nxtInstr  = in_instr;
  assign w_nxtCtrl   = in_ctrl;
  assign w_nxtData   = in_data;
`endif

  // Flush beats hold, which beats load/drain; out_data is left alone on flush and drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_ctrl  <= '0;
    end else if (!hold) begin
      if (w_mainLoad) begin
        r_valid <= 1'b1;
        r_instr <= w_nxtInstr;
        r_ctrl  <= w_nxtCtrl;
        r_data  <= w_nxtData;
      end else if (w_mainDrain) begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
        r_ctrl  <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubbleCnt <= '0;
    end else if (!r_valid && !hold && !flush && (r_bubbleCnt != '1)) begin
      r_bubbleCnt <= r_bubbleCnt + CNT_W'(1);
    end
  end

  assign out_valid  = r_valid;
  assign out_instr  = r_instr;
  assign out_ctrl   = r_ctrl;
  assign out_data   = r_data;
  assign bubble_cnt = r_bubbleCnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue model of the stage plus directed literals.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst, flush, hold, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_ctrl;
  logic [95:0] in_data;

  wire         in_ready, out_valid;
  wire  [31:0] out_instr;
  wire  [7:0]  out_ctrl;
  wire  [95:0] out_data;
  wire  [15:0] bubble_cnt;

  wire         in_ready4, out_valid4;
  wire  [31:0] out_instr4;
  wire  [7:0]  out_ctrl4;
  wire  [95:0] out_data4;
  wire  [3:0]  bubble_cnt4;

  pipe_stage_reg #(.INSTR_W(32), .CTRL_W(8), .DATA_W(96), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_ctrl(out_ctrl),
    .out_data(out_data), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.INSTR_W(32), .CTRL_W(8), .DATA_W(96), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready4), .in_instr(in_instr), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_instr(out_instr4), .out_ctrl(out_ctrl4),
    .out_data(out_data4), .bubble_cnt(bubble_cnt4)
  );

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  ctrl;
    logic [95:0] data;
  } pay_t;

  pay_t        mq[$];
  logic [31:0] srcQ[$];
  logic [31:0] rxQ[$];
  int unsigned bub16, bub4;
  int          checks = 0;
  int          errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mkCtrl(input logic [31:0] instr);
    return instr[7:0] ^ instr[31:24];
  endfunction

  function automatic logic [95:0] mkData(input logic [31:0] instr);
    return {instr, ~instr, instr ^ 32'hA5A5_A5A5};
  endfunction

  function automatic bit modelReady();
    if (hold) return 1'b0;
    if (CAP == 2) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic outReady, input logic holdIn, input logic flushIn);
    in_valid  = (srcQ.size() > 0);
    in_instr  = in_valid ? srcQ[0] : 32'h0;
    in_ctrl   = mkCtrl(in_instr);
    in_data   = mkData(in_instr);
    out_ready = outReady;
    hold      = holdIn;
    flush     = flushIn;
    @(posedge clk);
    #1;
  endtask

  // Model: the stage is a FIFO of capacity CAP with a saturating idle-cycle count.
  initial begin : model
    bit rdy, pop;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        bub16 = 0;
        bub4  = 0;
      end else if (flush) begin
        mq.delete();
      end else if (!hold) begin
        rdy = modelReady();
        if (mq.size() == 0) begin
          if (bub16 < 65535) bub16++;
          if (bub4 < 15) bub4++;
        end
        pop = (mq.size() > 0) && out_ready;
        if (pop) void'(mq.pop_front());
        if (in_valid && rdy) mq.push_back('{in_instr, in_ctrl, in_data});
      end
    end
  end

  // Upstream source and downstream receive log.
  initial begin : srcSink
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (in_valid && in_ready && srcQ.size() > 0) void'(srcQ.pop_front());
        if (out_valid && out_ready && !hold && !flush) rxQ.push_back(out_instr);
      end
    end
  end

  initial begin : compare
    logic        expValid;
    logic [31:0] expInstr;
    logic [7:0]  expCtrl;
    forever begin
      @(negedge clk);
      expValid = (mq.size() > 0);
      expInstr = expValid ? mq[0].instr : NOP;
      expCtrl  = expValid ? mq[0].ctrl  : 8'h00;
      checkOutput("cmp_out_valid", 128'(out_valid), 128'(expValid));
      checkOutput("cmp_out_instr", 128'(out_instr), 128'(expInstr));
      checkOutput("cmp_out_ctrl", 128'(out_ctrl), 128'(expCtrl));
      checkOutput("cmp_in_ready", 128'(in_ready), 128'(rst ? 1'b0 : modelReady()));
      checkOutput("cmp_bubble16", 128'(bubble_cnt), 128'(bub16));
      checkOutput("cmp_bubble4", 128'(bubble_cnt4), 128'(bub4));
      checkOutput("cmp_out_valid4", 128'(out_valid4), 128'(expValid));
      checkOutput("cmp_out_instr4", 128'(out_instr4), 128'(expInstr));
      if (rst) checkOutput("cmp_out_data_rst", 128'(out_data), 128'(0));
      else if (expValid) checkOutput("cmp_out_data", 128'(out_data), 128'(mq[0].data));
    end
  end

  initial begin : stimulus
    logic [31:0] streamI[4];
    logic [31:0] expRx[6];
    streamI = '{32'h00A0_0093, 32'h0010_0113, 32'h0020_81B3, 32'h0031_2023};
    expRx   = '{32'h00A0_0093, 32'h0010_0113, 32'h0020_81B3, 32'h0031_2023,
                32'h0020_81B3, 32'h0040_8233};
    rst = 1'b1; flush = 1'b0; hold = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_ctrl = '0; in_data = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_out_instr", 128'(out_instr), 128'(32'h0000_0013));
    checkOutput("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    checkOutput("rst_out_data", 128'(out_data), 128'(0));
    checkOutput("rst_bubble", 128'(bubble_cnt), 128'(0));
    checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;

    for (int k = 0; k < 4; k++) srcQ.push_back(streamI[k]);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("stream_valid", 128'(out_valid), 128'(1));
      checkOutput("stream_instr", 128'(out_instr), 128'(streamI[k]));
    end

    srcQ.push_back(32'h0020_81B3);
    srcQ.push_back(32'h0040_8233);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("bp_instr_stable", 128'(out_instr), 128'(32'h0020_81B3));
    end
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rx_count", 128'(rxQ.size()), 128'(6));
    for (int i = 0; i < 6 && i < rxQ.size(); i++) checkOutput("rx_order", 128'(rxQ[i]), 128'(expRx[i]));

    srcQ.push_back(32'h0050_0293);
    srcQ.push_back(32'h0060_0313);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    srcQ.push_back(32'h0070_0393);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("flush_valid", 128'(out_valid), 128'(0));
    checkOutput("flush_instr", 128'(out_instr), 128'(32'h0000_0013));
    checkOutput("flush_ctrl", 128'(out_ctrl), 128'(0));
    srcQ.delete();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("flush_all_empty", 128'(out_valid), 128'(0));

    checkOutput("bubble_before_hold", 128'(bubble_cnt), 128'(4));
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("bubble_hold", 128'(bubble_cnt), 128'(4));
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("bubble_idle", 128'(bubble_cnt), 128'(9));

    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("sat_bubble4", 128'(bubble_cnt4), 128'(4'hF));
    checkOutput("sat_bubble16", 128'(bubble_cnt), 128'(29));
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("sat_bubble4_stay", 128'(bubble_cnt4), 128'(4'hF));

    srcQ.push_back(32'h0070_0393);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("mid_loaded", 128'(out_valid), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 128'(out_valid), 128'(0));
    checkOutput("mid_rst_instr", 128'(out_instr), 128'(32'h0000_0013));
    checkOutput("mid_rst_ctrl", 128'(out_ctrl), 128'(0));
    checkOutput("mid_rst_bubble", 128'(bubble_cnt), 128'(0));
    checkOutput("mid_rst_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    srcQ.delete();
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
